// File: rtl/obi_rr_arbiter.sv
// Round-robin arbiter merging NUM_MST OBI masters onto one OBI slave port.
// An in-order ID FIFO routes each response back to the master that issued it.
module obi_rr_arbiter #(
  parameter int unsigned NUM_MST         = 2,
  parameter int unsigned OBI_ADDRW       = 32,
  parameter int unsigned OBI_DATAW       = 32,
  parameter int unsigned OBI_STRBW       = OBI_DATAW / 8,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                           clk_i,
  input  logic                           arst_ni,
  input  logic [NUM_MST-1:0]             mst_req_i,
  output logic [NUM_MST-1:0]             mst_gnt_o,
  input  logic [NUM_MST*OBI_ADDRW-1:0]   mst_addr_i,
  input  logic [NUM_MST-1:0]             mst_we_i,
  input  logic [NUM_MST*OBI_DATAW-1:0]   mst_wdata_i,
  input  logic [NUM_MST*OBI_STRBW-1:0]   mst_be_i,
  output logic [NUM_MST-1:0]             mst_rvalid_o,
  output logic [OBI_DATAW-1:0]           mst_rdata_o,
  output logic                           slv_req_o,
  input  logic                           slv_gnt_i,
  output logic [OBI_ADDRW-1:0]           slv_addr_o,
  output logic                           slv_we_o,
  output logic [OBI_DATAW-1:0]           slv_wdata_o,
  output logic [OBI_STRBW-1:0]           slv_be_o,
  input  logic                           slv_rvalid_i,
  input  logic [OBI_DATAW-1:0]           slv_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding_o,
  output logic                           err_o
);

  localparam int unsigned IDW  = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
  localparam int unsigned PTRW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNTW = $clog2(MAX_OUTSTANDING) + 1;

  logic [OBI_ADDRW-1:0] addr_arr  [NUM_MST];
  logic [OBI_DATAW-1:0] wdata_arr [NUM_MST];
  logic [OBI_STRBW-1:0] be_arr    [NUM_MST];

  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic            lock_q, lock_d;
  logic [IDW-1:0]  lock_idx_q, lock_idx_d;
  logic [IDW-1:0]  id_mem_q [MAX_OUTSTANDING];
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  logic [IDW-1:0]  rr_sel, sel, head;
  logic [IDW:0]    scan_pos;
  logic            rr_found, full, empty, hs, pop;

  for (genvar g = 0; g < NUM_MST; g++) begin : g_unpack
    assign addr_arr[g]  = mst_addr_i[g*OBI_ADDRW +: OBI_ADDRW];
    assign wdata_arr[g] = mst_wdata_i[g*OBI_DATAW +: OBI_DATAW];
    assign be_arr[g]    = mst_be_i[g*OBI_STRBW +: OBI_STRBW];
  end

  // First requester at or after rr_ptr_q, wrapping modulo NUM_MST.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rr_sel   = '0;
    rr_found = 1'b0;
    scan_pos = '0;
    for (int unsigned k = 0; k < NUM_MST; k++) begin
      scan_pos = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (scan_pos >= (IDW+1)'(NUM_MST)) scan_pos = scan_pos - (IDW+1)'(NUM_MST);
      if (!rr_found && mst_req_i[scan_pos[IDW-1:0]]) begin
        rr_sel   = scan_pos[IDW-1:0];
        rr_found = 1'b1;
      end
    end
  end

  assign sel   = lock_q ? lock_idx_q : rr_sel;
  assign full  = (cnt_q == CNTW'(MAX_OUTSTANDING));
  assign empty = (cnt_q == '0);
  assign head  = id_mem_q[rd_ptr_q];

  assign slv_req_o   = (lock_q | (|mst_req_i)) & ~full;
  assign hs          = slv_req_o & slv_gnt_i;
  assign pop         = slv_rvalid_i & ~empty;
  assign slv_addr_o  = addr_arr[sel];
  assign slv_we_o    = mst_we_i[sel];
  assign slv_wdata_o = wdata_arr[sel];
  assign slv_be_o    = be_arr[sel];

  assign mst_gnt_o     = hs  ? (NUM_MST'(1) << sel)  : '0;
  assign mst_rvalid_o  = pop ? (NUM_MST'(1) << head) : '0;
  assign mst_rdata_o   = slv_rdata_i;
  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    err_d      = err_q | (slv_rvalid_i & empty);

    if (hs) begin
      rr_ptr_d = (sel == IDW'(NUM_MST - 1)) ? '0 : sel + IDW'(1);
      lock_d   = 1'b0;
      wr_ptr_d = (wr_ptr_q == PTRW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + PTRW'(1);
    end else if (slv_req_o) begin
      // Address phase must stay stable until the bridge grants it.
      lock_d     = 1'b1;
      lock_idx_d = sel;
    end

    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTRW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + PTRW'(1);
    end

    case ({hs, pop})
      2'b10:   cnt_d = cnt_q + CNTW'(1);
      2'b01:   cnt_d = cnt_q - CNTW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  // NOTE: ID storage is deliberately not reset; the count and pointers alone mark valid entries.
  always_ff @(posedge clk_i) begin
    if (hs) id_mem_q[wr_ptr_q] <= sel;
  end

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Self-checking bench for obi_rr_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a queue model.
module tb_obi_rr_arbiter;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MO = 4;
  localparam int CW = $clog2(MO) + 1;

  logic              clk;
  logic              arst_ni;
  logic [NM-1:0]     mst_req_i, mst_gnt_o, mst_we_i, mst_rvalid_o;
  logic [NM*AW-1:0]  mst_addr_i;
  logic [NM*DW-1:0]  mst_wdata_i;
  logic [NM*BW-1:0]  mst_be_i;
  logic [DW-1:0]     mst_rdata_o;
  logic              slv_req_o, slv_gnt_i, slv_we_o, slv_rvalid_i, err_o;
  logic [AW-1:0]     slv_addr_o;
  logic [DW-1:0]     slv_wdata_o, slv_rdata_i;
  logic [BW-1:0]     slv_be_o;
  logic [CW-1:0]     outstanding_o;

  int errors = 0;
  int checks = 0;

  obi_rr_arbiter #(
    .NUM_MST(NM), .OBI_ADDRW(AW), .OBI_DATAW(DW), .OBI_STRBW(BW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk), .arst_ni(arst_ni),
    .mst_req_i(mst_req_i), .mst_gnt_o(mst_gnt_o), .mst_addr_i(mst_addr_i),
    .mst_we_i(mst_we_i), .mst_wdata_i(mst_wdata_i), .mst_be_i(mst_be_i),
    .mst_rvalid_o(mst_rvalid_o), .mst_rdata_o(mst_rdata_o),
    .slv_req_o(slv_req_o), .slv_gnt_i(slv_gnt_i), .slv_addr_o(slv_addr_o),
    .slv_we_o(slv_we_o), .slv_wdata_o(slv_wdata_o), .slv_be_o(slv_be_o),
    .slv_rvalid_i(slv_rvalid_i), .slv_rdata_i(slv_rdata_i),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: queue of issuer IDs in issue order, the index at which the
  // next round-robin scan starts, the master whose request is pending a grant.
  int m_q[$];
  int m_rr    = 0;
  bit m_pend  = 0;
  int m_pidx  = 0;
  bit m_err   = 0;

  always @(negedge clk) begin : compare
    int cand, esel;
    bit found, any, ereq;
    logic [NM-1:0] egnt, erv;
    if (!arst_ni) begin
      m_q.delete();
      m_rr = 0; m_pend = 0; m_pidx = 0; m_err = 0;
      if (mst_req_i == '0 && slv_rvalid_i == 1'b0) begin
        check("rst_slv_req", 64'(slv_req_o), 64'd0);
        check("rst_gnt", 64'(mst_gnt_o), 64'd0);
        check("rst_rvalid", 64'(mst_rvalid_o), 64'd0);
        check("rst_outstanding", 64'(outstanding_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
      end
    end else begin
      cand = 0;
      found = 0;
      if (m_pend) cand = m_pidx;
      else begin
        for (int k = 0; k < NM; k++) begin
          if (!found && mst_req_i[(m_rr + k) % NM]) begin
            cand = (m_rr + k) % NM;
            found = 1;
          end
        end
      end
      any  = m_pend || (mst_req_i != '0);
      ereq = any && (m_q.size() < MO);
      esel = any ? cand : 0;
      egnt = '0;
      if (ereq && slv_gnt_i) egnt[cand] = 1'b1;
      erv = '0;
      if (slv_rvalid_i && m_q.size() > 0) erv[m_q[0]] = 1'b1;

      check("slv_req", 64'(slv_req_o), 64'(ereq));
      check("mst_gnt", 64'(mst_gnt_o), 64'(egnt));
      check("mst_rvalid", 64'(mst_rvalid_o), 64'(erv));
      check("mst_rdata", 64'(mst_rdata_o), 64'(slv_rdata_i));
      check("slv_addr", 64'(slv_addr_o), 64'(mst_addr_i[esel*AW +: AW]));
      check("slv_we", 64'(slv_we_o), 64'(mst_we_i[esel]));
      check("slv_wdata", 64'(slv_wdata_o), 64'(mst_wdata_i[esel*DW +: DW]));
      check("slv_be", 64'(slv_be_o), 64'(mst_be_i[esel*BW +: BW]));
      check("outstanding", 64'(outstanding_o), 64'(m_q.size()));
      check("err", 64'(err_o), 64'(m_err));

      if (slv_rvalid_i) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        else m_err = 1;
      end
      if (ereq) begin
        if (slv_gnt_i) begin
          m_q.push_back(cand);
          m_rr   = (cand + 1) % NM;
          m_pend = 0;
        end else begin
          m_pend = 1;
          m_pidx = cand;
        end
      end
    end
  end

  task automatic clr();
    mst_req_i = '0; mst_we_i = '0; mst_addr_i = '0; mst_wdata_i = '0; mst_be_i = '0;
    slv_gnt_i = 1'b0; slv_rvalid_i = 1'b0; slv_rdata_i = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    clr();
    arst_ni = 1'b0;
    repeat (2) @(posedge clk);
    #1 arst_ni = 1'b1;
  endtask

  logic [NM-1:0] pat [4];
  logic [NM-1:0] gnt_seen;

  initial begin
    clr();
    arst_ni = 1'b1;
    #1 arst_ni = 1'b0;
    #1;
    check("t0_slv_req", 64'(slv_req_o), 64'd0);
    check("t0_gnt", 64'(mst_gnt_o), 64'd0);
    check("t0_outstanding", 64'(outstanding_o), 64'd0);
    check("t0_err", 64'(err_o), 64'd0);
    repeat (2) @(posedge clk);
    #1 arst_ni = 1'b1;

    // Single read from master 0, response two cycles later.
    mst_req_i = 2'b01; mst_addr_i[0 +: AW] = 32'h1000; slv_gnt_i = 1'b1;
    mid();
    check("t1_gnt", 64'(mst_gnt_o), 64'h1);
    check("t1_addr", 64'(slv_addr_o), 64'h1000);
    check("t1_out0", 64'(outstanding_o), 64'd0);
    tick(); mst_req_i = '0; slv_gnt_i = 1'b0;
    mid();
    check("t1_out1", 64'(outstanding_o), 64'd1);
    tick(); slv_rvalid_i = 1'b1; slv_rdata_i = 32'hDEADBEEF;
    mid();
    check("t1_rvalid", 64'(mst_rvalid_o), 64'h1);
    check("t1_rdata", 64'(mst_rdata_o), 64'hDEADBEEF);
    tick(); slv_rvalid_i = 1'b0;
    mid();
    check("t1_out2", 64'(outstanding_o), 64'd0);

    // Fairness with both masters requesting continuously.
    pat[0] = 2'b01; pat[1] = 2'b10; pat[2] = 2'b01; pat[3] = 2'b10;
    do_reset();
    mst_req_i = 2'b11; mst_addr_i = {32'hB000_0000, 32'hA000_0000}; slv_gnt_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mid(); check("t2_gnt", 64'(mst_gnt_o), 64'(pat[k])); tick();
    end
    mst_req_i = '0; slv_gnt_i = 1'b0; slv_rvalid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      slv_rdata_i = $urandom();
      mid(); check("t2_rvalid", 64'(mst_rvalid_o), 64'(pat[k])); tick();
    end
    slv_rvalid_i = 1'b0;

    // Locked address phase: master 1 waits, master 0 joins in cycle 2.
    do_reset();
    mst_req_i = 2'b10; mst_addr_i[AW +: AW] = 32'h2000_0004;
    mid(); check("t3_addr_c1", 64'(slv_addr_o), 64'h2000_0004);
    check("t3_gnt_c1", 64'(mst_gnt_o), 64'h0);
    tick(); mst_req_i = 2'b11; mst_addr_i[0 +: AW] = 32'h3000_0000;
    mid(); check("t3_addr_c2", 64'(slv_addr_o), 64'h2000_0004);
    tick();
    mid(); check("t3_addr_c3", 64'(slv_addr_o), 64'h2000_0004);
    tick(); slv_gnt_i = 1'b1;
    mid(); check("t3_first_gnt", 64'(mst_gnt_o), 64'h2);
    tick(); mst_req_i = 2'b01;
    mid(); check("t3_second_gnt", 64'(mst_gnt_o), 64'h1);
    check("t3_addr_m0", 64'(slv_addr_o), 64'h3000_0000);
    tick(); mst_req_i = '0; slv_gnt_i = 1'b0; slv_rvalid_i = 1'b1;
    mid(); check("t3_rv_first", 64'(mst_rvalid_o), 64'h2);
    tick();
    mid(); check("t3_rv_second", 64'(mst_rvalid_o), 64'h1);
    tick(); slv_rvalid_i = 1'b0;

    // Full tracker blocks requests, including the cycle a pop relieves it.
    do_reset();
    mst_req_i = 2'b11; slv_gnt_i = 1'b1;
    repeat (4) tick();
    mid(); check("t4_req_full", 64'(slv_req_o), 64'd0);
    check("t4_out_full", 64'(outstanding_o), 64'd4);
    tick(); slv_rvalid_i = 1'b1; slv_rdata_i = 32'h1234_5678;
    mid(); check("t4_req_popcyc", 64'(slv_req_o), 64'd0);
    check("t4_rv_first_issuer", 64'(mst_rvalid_o), 64'h1);
    tick(); slv_rvalid_i = 1'b0;
    mid(); check("t4_req_resume", 64'(slv_req_o), 64'd1);
    check("t4_out3", 64'(outstanding_o), 64'd3);
    check("t4_gnt_resume", 64'(mst_gnt_o), 64'h1);
    tick(); mst_req_i = '0; slv_gnt_i = 1'b0; slv_rvalid_i = 1'b1;
    mid(); check("t4_drain_head", 64'(mst_rvalid_o), 64'h2);
    repeat (4) tick();
    slv_rvalid_i = 1'b0;

    // Unexpected response sets the sticky error.
    do_reset();
    slv_rvalid_i = 1'b1;
    mid(); check("t5_rv_none", 64'(mst_rvalid_o), 64'h0);
    check("t5_err_pre", 64'(err_o), 64'd0);
    tick(); slv_rvalid_i = 1'b0;
    mid(); check("t5_err_set", 64'(err_o), 64'd1);
    check("t5_out", 64'(outstanding_o), 64'd0);
    repeat (3) tick();
    mid(); check("t5_err_sticky", 64'(err_o), 64'd1);
    tick();

    // Asynchronous reset with three transactions in flight.
    do_reset();
    mst_req_i = 2'b11; slv_gnt_i = 1'b1;
    repeat (3) tick();
    mst_req_i = '0; slv_gnt_i = 1'b0;
    mid(); check("t6_out3", 64'(outstanding_o), 64'd3);
    #2 arst_ni = 1'b0;
    #1;
    check("t6_rst_req", 64'(slv_req_o), 64'd0);
    check("t6_rst_gnt", 64'(mst_gnt_o), 64'd0);
    check("t6_rst_rvalid", 64'(mst_rvalid_o), 64'd0);
    check("t6_rst_out", 64'(outstanding_o), 64'd0);
    check("t6_rst_err", 64'(err_o), 64'd0);
    repeat (2) @(posedge clk);
    #1 arst_ni = 1'b1;
    mst_req_i = 2'b10; mst_addr_i[AW +: AW] = 32'h4000_0040; slv_gnt_i = 1'b1;
    mid(); check("t6_post_gnt", 64'(mst_gnt_o), 64'h2);
    tick(); mst_req_i = '0; slv_gnt_i = 1'b0;
    tick(); slv_rvalid_i = 1'b1; slv_rdata_i = 32'hCAFE_F00D;
    mid(); check("t6_post_rv", 64'(mst_rvalid_o), 64'h2);
    tick(); slv_rvalid_i = 1'b0;

    // Randomized OBI-compliant traffic: a presented request holds until granted.
    do_reset();
    gnt_seen = '0;
    for (int c = 0; c < 3000; c++) begin
      int gnt_pct, rv_pct;
      gnt_pct = ((c / 500) % 2 == 0) ? 80 : 30;
      rv_pct  = ((c / 250) % 3 == 0) ? 20 : 60;
      for (int i = 0; i < NM; i++) begin
        if (!(mst_req_i[i] && !gnt_seen[i])) begin
          mst_req_i[i] = ($urandom_range(0, 99) < 60);
          mst_we_i[i]  = 1'($urandom_range(0, 1));
          mst_addr_i[i*AW +: AW]  = $urandom();
          mst_wdata_i[i*DW +: DW] = $urandom();
          mst_be_i[i*BW +: BW]    = BW'($urandom());
        end
      end
      slv_gnt_i    = ($urandom_range(0, 99) < gnt_pct);
      slv_rvalid_i = (m_q.size() > 0) && ($urandom_range(0, 99) < rv_pct);
      slv_rdata_i  = $urandom();
      mid();
      gnt_seen = mst_gnt_o;
      tick();
    end
    clr();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
